// File: rtl/addsub_pipe_pkg.sv
// Shared encodings and carry-chain split helpers for the two-stage adder/subtractor.
package addsub_pipe_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Width of the low segment, computed in stage 1.
    function automatic int lo_w(input int width);
        return width / 2;
    endfunction

    // Width of the high segment, computed in stage 2 (takes the odd bit).
    function automatic int hi_w(input int width);
        return width - (width / 2);
    endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand-in / result-out handshake bundle between the producer, the pipe and the checker.
interface addsub_pipe_if #(parameter int WIDTH = 4);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             in_addsub;
    logic             in_tc;
    logic             in_sat;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_a;
    logic             out_b;
    logic             out_addsub;
    logic             out_tc;
    logic             out_sat;

    modport master (
        output in_valid, in_a, in_b, in_ci, in_addsub, in_tc, in_sat, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_a, out_b,
               out_addsub, out_tc, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, in_addsub, in_tc, in_sat, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_a, out_b,
               out_addsub, out_tc, out_sat
    );

endinterface

// File: rtl/addsub_seg.sv
// n-bit ripple-carry segment; one instance per pipeline stage.
module addsub_seg #(
    parameter int N = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    // Bit-serial carry ripple from LSB to MSB.
    always_comb begin
        logic c;
        s = '0;
        c = ci;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined adder/subtractor feeding the saturation checker.
// Subtract is done as A + ~B + ~bin; the internal carry is flipped back to a borrow at the output.
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    addsub_pipe_if.slave  bus
);

    localparam int LO = lo_w(WIDTH);
    localparam int HI = hi_w(WIDTH);

    logic             is_sub;
    logic [WIDTH-1:0] b_cond;
    logic             ci_int;
    logic [LO-1:0]    lo_sum;
    logic             lo_co;
    logic [HI-1:0]    hi_sum;
    logic             hi_co;
    logic             s2_adv;
    logic             accept;

    logic             s1_valid;
    logic [LO-1:0]    s1_sum_lo;
    logic             s1_c_lo;
    logic [HI-1:0]    s1_a_hi;
    logic [HI-1:0]    s1_b_hi;
    logic             s1_msb_a;
    logic             s1_msb_b;
    logic             s1_addsub;
    logic             s1_tc;
    logic             s1_sat;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_carry;
    logic             s2_msb_a;
    logic             s2_msb_b;
    logic             s2_addsub;
    logic             s2_tc;
    logic             s2_sat;

    assign is_sub = (bus.in_addsub == SUB);
    assign b_cond = bus.in_b ^ {WIDTH{is_sub}};
    assign ci_int = bus.in_ci ^ is_sub;

    // Output stage may load when it is empty or its current result is being taken.
    assign s2_adv       = s1_valid & (~s2_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s2_adv;
    assign accept       = bus.in_valid & bus.in_ready;

    addsub_seg #(.N(LO)) u_seg_lo (
        .a  (bus.in_a[LO-1:0]),
        .b  (b_cond[LO-1:0]),
        .ci (ci_int),
        .s  (lo_sum),
        .co (lo_co)
    );

    addsub_seg #(.N(HI)) u_seg_hi (
        .a  (s1_a_hi),
        .b  (s1_b_hi),
        .ci (s1_c_lo),
        .s  (hi_sum),
        .co (hi_co)
    );

    // Stage 1: low-half sum plus everything the high half and the checker still need.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sum_lo <= '0;
            s1_c_lo   <= 1'b0;
            s1_a_hi   <= '0;
            s1_b_hi   <= '0;
            s1_msb_a  <= 1'b0;
            s1_msb_b  <= 1'b0;
            s1_addsub <= 1'b0;
            s1_tc     <= 1'b0;
            s1_sat    <= 1'b0;
        end else begin
            if (clr)
                s1_valid <= 1'b0;
            else if (accept)
                s1_valid <= 1'b1;
            else if (s2_adv)
                s1_valid <= 1'b0;

            if (accept) begin
                s1_sum_lo <= lo_sum;
                s1_c_lo   <= lo_co;
                s1_a_hi   <= bus.in_a[WIDTH-1:LO];
                s1_b_hi   <= b_cond[WIDTH-1:LO];
                s1_msb_a  <= bus.in_a[WIDTH-1];
                s1_msb_b  <= bus.in_b[WIDTH-1];
                s1_addsub <= bus.in_addsub;
                s1_tc     <= bus.in_tc;
                s1_sat    <= bus.in_sat;
            end
        end
    end

    // Stage 2: finish the carry chain and hold the result until the checker takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_carry  <= 1'b0;
            s2_msb_a  <= 1'b0;
            s2_msb_b  <= 1'b0;
            s2_addsub <= 1'b0;
            s2_tc     <= 1'b0;
            s2_sat    <= 1'b0;
        end else begin
            if (clr)
                s2_valid <= 1'b0;
            else if (s2_adv)
                s2_valid <= 1'b1;
            else if (bus.out_ready)
                s2_valid <= 1'b0;

            if (s2_adv) begin
                s2_sum    <= {hi_sum, s1_sum_lo};
                s2_carry  <= hi_co ^ s1_addsub;
                s2_msb_a  <= s1_msb_a;
                s2_msb_b  <= s1_msb_b;
                s2_addsub <= s1_addsub;
                s2_tc     <= s1_tc;
                s2_sat    <= s1_sat;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_sum    = s2_sum;
    assign bus.out_carry  = s2_carry;
    assign bus.out_a      = s2_msb_a;
    assign bus.out_b      = s2_msb_b;
    assign bus.out_addsub = s2_addsub;
    assign bus.out_tc     = s2_tc;
    assign bus.out_sat    = s2_sat;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: vector table, backpressure, streaming, clr and async reset.
module tb_addsub_pipe;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic       addsub;
        logic       tc;
        logic       sat;
        logic [3:0] e_sum;
        logic       e_carry;
        logic       e_ma;
        logic       e_mb;
    } vec_t;

    logic clk;
    logic rst_n;
    logic clr;

    int checks   = 0;
    int failures = 0;
    int rx_count = 0;
    logic mon_en = 1'b0;
    logic [9:0] q[$];

    addsub_pipe_if #(.WIDTH(4)) bus ();

    addsub_pipe #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic, borrow = unsigned A < B+ci.
    function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci, input logic addsub,
                                         input logic tc, input logic sat);
        logic [4:0] full;
        logic       c;
        if (!addsub) begin
            full = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            c    = full[4];
        end else begin
            full = {1'b0, a} - {1'b0, b} - {4'b0, ci};
            c    = ({1'b0, a} < ({1'b0, b} + {4'b0, ci}));
        end
        return {tc, sat, addsub, a[3], b[3], c, full[3:0]};
    endfunction

    function automatic logic [9:0] out_pack();
        return {bus.out_tc, bus.out_sat, bus.out_addsub, bus.out_a, bus.out_b,
                bus.out_carry, bus.out_sum};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic addsub, input logic tc, input logic sat);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_ci     = ci;
        bus.in_addsub = addsub;
        bus.in_tc     = tc;
        bus.in_sat    = sat;
        #1;
        if (bus.in_ready && !clr)
            q.push_back(model(a, b, ci, addsub, tc, sat));
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q.size() != 0 || bus.out_valid) && k < 20) begin
            step();
            k++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    // Scoreboard: a transfer is seen mid-cycle and completes at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("mon_extra", 32'(out_pack()), 32'h3ff);
                end else begin
                    chk("mon_result", 32'(out_pack()), 32'(q[0]));
                    void'(q.pop_front());
                end
                rx_count++;
            end
        end
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{4'b1000, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'b0101, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{4'b0110, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0};

        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.in_ci     = 1'b0;
        bus.in_addsub = 1'b0;
        bus.in_tc     = 1'b0;
        bus.in_sat    = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_out_carry", 32'(bus.out_carry), 32'd0);

        // Table vectors, one at a time through an empty pipe.
        for (int i = 0; i < 8; i++) begin
            offer(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].addsub, vecs[i].tc, vecs[i].sat);
            q.delete();
            step();
            bus.in_valid = 1'b0;
            chk("vec_lat1_valid", 32'(bus.out_valid), 32'd0);
            step();
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_sum", 32'(bus.out_sum), 32'(vecs[i].e_sum));
            chk("vec_carry", 32'(bus.out_carry), 32'(vecs[i].e_carry));
            chk("vec_msb", 32'({bus.out_a, bus.out_b}), 32'({vecs[i].e_ma, vecs[i].e_mb}));
            chk("vec_ctrl", 32'({bus.out_addsub, bus.out_tc, bus.out_sat}),
                32'({vecs[i].addsub, vecs[i].tc, vecs[i].sat}));
            step();
            chk("vec_valid_fall", 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: two accepts fill the pipe, third waits for out_ready.
        mon_en        = 1'b1;
        rx_count      = 0;
        bus.out_ready = 1'b0;
        offer(4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        step();
        offer(4'd9, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("bp_ready2", 32'(bus.in_ready), 32'd1);
        step();
        offer(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("bp_ready_drop", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold", 32'(out_pack()), 32'(q[0]));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_passthru", 32'(bus.in_ready), 32'd1);
        q.push_back(model(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1));
        step();
        bus.in_valid = 1'b0;
        drain("bp_drain");
        chk("bp_count", 32'(rx_count), 32'd3);

        // Streaming: one item per cycle with the consumer always ready.
        rx_count = 0;
        for (int i = 0; i < 16; i++) begin
            offer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("st_ready", 32'(bus.in_ready), 32'd1);
            step();
            if (i >= 1)
                chk("st_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("st_valid_last", 32'(bus.out_valid), 32'd1);
        drain("st_drain");
        chk("st_count", 32'(rx_count), 32'd16);

        // clr with two items in flight, then a dropped accept under clr.
        rx_count      = 0;
        bus.out_ready = 1'b0;
        offer(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        offer(4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        clr = 1'b1;
        offer(4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        q.delete();
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
        offer(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        clr           = 1'b0;
        bus.out_ready = 1'b1;
        offer(4'd10, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("clr_drop", 32'(bus.out_valid), 32'd0);
        drain("clr_drain");
        chk("clr_count", 32'(rx_count), 32'd1);

        // Async reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            offer(4'(i + 2), 4'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
        q.delete();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        rx_count = 0;
        chk("rst_rel_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rel_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_rel_sum", 32'(bus.out_sum), 32'd0);
        offer(4'd12, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        drain("rst_drain");
        chk("rst_count", 32'(rx_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
